// File: rtl/pp_accum_pkg.sv
// Shared definitions for the partial-product accumulation sequencer.
// Contents: default operand/result widths, fixed radix alignment offsets
// for the six partial products, and the controller state encoding.
package pp_accum_pkg;

    localparam int SIZE  = 45;
    localparam int RADIX = 54;
    localparam int RES_W = 2 * RADIX;

    // Left-shift applied to each partial product before accumulation.
    localparam int OFF_0 = 0;
    localparam int OFF_1 = 18;
    localparam int OFF_2 = 36;
    localparam int OFF_3 = 27;
    localparam int OFF_4 = 45;
    localparam int OFF_5 = 63;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC0 = 3'd1,
        ST_ACC1 = 3'd2,
        ST_ACC2 = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/pp_accum_add3.sv
// Combinational three-input adder, result truncated to W bits.
// Ports:
//   x, y, z : W-bit addends
//   sum     : (x + y + z) mod 2^W
module pp_accum_add3 #(
    parameter int W = 108
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum
);

    assign sum = x + y + z;

endmodule

// File: rtl/pp_accum_seq.sv
// Partial-product accumulation sequencer. Captures six aligned partial
// products per transaction and sums them over three cycles through a single
// shared three-input adder, then presents the 2*radix-bit result.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand-set handshake
//   a_0 .. a_5          : Size-bit partial products
//   abort               : cancel in-flight transaction (ignored in IDLE)
//   out_valid/out_ready : result handshake
//   res                 : accumulated sum mod 2^(2*radix)
//   busy                : high whenever not IDLE
module pp_accum_seq
    import pp_accum_pkg::*;
#(
    parameter int Size  = SIZE,
    parameter int radix = RADIX
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [Size-1:0]      a_0,
    input  logic [Size-1:0]      a_1,
    input  logic [Size-1:0]      a_2,
    input  logic [Size-1:0]      a_3,
    input  logic [Size-1:0]      a_4,
    input  logic [Size-1:0]      a_5,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*radix-1:0]   res,
    output logic                 busy
);

    localparam int RW = 2 * radix;

    state_t          state_r;
    logic [RW-1:0]   p0_r, p1_r, p2_r, p3_r, p4_r, p5_r;
    logic [RW-1:0]   acc_r;
    logic            out_valid_r;
    logic            busy_r;
    logic            in_ready_s;
    logic            accept_s;
    logic [RW-1:0]   add_x_s, add_y_s, add_z_s, add_sum_s;

    // Handshake: abort blocks any capture in the same cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (abort) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = (state_r == ST_IDLE) ||
                         ((state_r == ST_DONE) && out_ready);
        end
        accept_s = in_valid && in_ready_s;
    end

    // State-driven operand mux in front of the shared adder.
    always_comb begin
        add_x_s = {RW{1'b0}};
        add_y_s = {RW{1'b0}};
        add_z_s = {RW{1'b0}};
        case (state_r)
            ST_ACC0: begin
                add_x_s = p0_r;
                add_y_s = p1_r;
                add_z_s = p2_r;
            end
            ST_ACC1: begin
                add_x_s = acc_r;
                add_y_s = p3_r;
                add_z_s = p4_r;
            end
            ST_ACC2: begin
                add_x_s = acc_r;
                add_y_s = p5_r;
                add_z_s = {RW{1'b0}};
            end
            default: begin
                add_x_s = {RW{1'b0}};
                add_y_s = {RW{1'b0}};
                add_z_s = {RW{1'b0}};
            end
        endcase
    end

    pp_accum_add3 #(.W(RW)) u_add3 (
        .x   (add_x_s),
        .y   (add_y_s),
        .z   (add_z_s),
        .sum (add_sum_s)
    );

    // Operand registers: capture zero-extended, pre-aligned operands on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_r <= {RW{1'b0}};
            p1_r <= {RW{1'b0}};
            p2_r <= {RW{1'b0}};
            p3_r <= {RW{1'b0}};
            p4_r <= {RW{1'b0}};
            p5_r <= {RW{1'b0}};
        end else if (accept_s) begin
            p0_r <= {{(RW-Size){1'b0}}, a_0} << OFF_0;
            p1_r <= {{(RW-Size){1'b0}}, a_1} << OFF_1;
            p2_r <= {{(RW-Size){1'b0}}, a_2} << OFF_2;
            p3_r <= {{(RW-Size){1'b0}}, a_3} << OFF_3;
            p4_r <= {{(RW-Size){1'b0}}, a_4} << OFF_4;
            p5_r <= {{(RW-Size){1'b0}}, a_5} << OFF_5;
        end else begin
            p0_r <= p0_r;
            p1_r <= p1_r;
            p2_r <= p2_r;
            p3_r <= p3_r;
            p4_r <= p4_r;
            p5_r <= p5_r;
        end
    end

    // Controller FSM with accumulator and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= {RW{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (abort && (state_r != ST_IDLE)) begin
            // Cancel wins over every other transition; the partial sum is dropped.
            state_r     <= ST_IDLE;
            acc_r       <= {RW{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_ACC0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_ACC0: begin
                    acc_r   <= add_sum_s;
                    state_r <= ST_ACC1;
                end
                ST_ACC1: begin
                    acc_r   <= add_sum_s;
                    state_r <= ST_ACC2;
                end
                ST_ACC2: begin
                    acc_r       <= add_sum_s;
                    state_r     <= ST_DONE;
                    out_valid_r <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        // A waiting operand set is taken on the same edge: no bubble.
                        if (accept_s) begin
                            state_r <= ST_ACC0;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    acc_r       <= {RW{1'b0}};
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign res       = acc_r;

endmodule

// File: tb/tb_pp_accum_seq.sv
module tb_pp_accum_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [44:0]  a_0, a_1, a_2, a_3, a_4, a_5;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [107:0] res;
    logic         busy;

    typedef struct {
        logic [107:0] res;
        int           vcyc;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   head_seen = 1'b0;

    pp_accum_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_0       (a_0),
        .a_1       (a_1),
        .a_2       (a_2),
        .a_3       (a_3),
        .a_4       (a_4),
        .a_5       (a_5),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [107:0] act, input logic [107:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Monitor: compare each presented result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %h expected no output", res);
            end else begin
                if (!head_seen) begin
                    tests++;
                    if (cyc != sb_q[0].vcyc) begin
                        fails++;
                        $display("FAIL latency: got cycle %0d expected cycle %0d", cyc, sb_q[0].vcyc);
                    end
                    head_seen = 1'b1;
                end
                tests++;
                if (res !== sb_q[0].res) begin
                    fails++;
                    $display("FAIL result: got %h expected %h", res, sb_q[0].res);
                end
                if (out_ready === 1'b1) begin
                    void'(sb_q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [44:0] v0, input logic [44:0] v1, input logic [44:0] v2,
                        input logic [44:0] v3, input logic [44:0] v4, input logic [44:0] v5,
                        input logic [107:0] exp_res, input bit push);
        int n;
        a_0 = v0; a_1 = v1; a_2 = v2; a_3 = v3; a_4 = v4; a_5 = v5;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
        end else if (push) begin
            sb_q.push_back('{exp_res, cyc + 4});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy === 1'b1) && n < 100) begin
            n++;
            @(posedge clk);
        end
        tests++;
        if (sb_q.size() != 0 || busy === 1'b1) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        a_0 = '0; a_1 = '0; a_2 = '0; a_3 = '0; a_4 = '0; a_5 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {107'd0, out_valid}, 108'd0);
        chk("rst_in_ready",  {107'd0, in_ready},  108'd1);
        chk("rst_busy",      {107'd0, busy},      108'd0);
        chk("rst_res",       res,                 108'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-bit: a_0 = 1.
        send(45'd1, 45'd0, 45'd0, 45'd0, 45'd0, 45'd0, 108'd1, 1'b1);
        chk("busy_after_accept", {107'd0, busy}, 108'd1);
        wait_drain();

        // All operands one: checks every offset.
        send(45'd1, 45'd1, 45'd1, 45'd1, 45'd1, 45'd1, 108'h8000_2010_0804_0001, 1'b1);
        wait_drain();

        // Wrap: a_4 = a_5 = 2^45-1 -> 2^90 - 2^63 - 2^45 mod 2^108.
        send(45'd0, 45'd0, 45'd0, 45'd0, 45'h1FFF_FFFF_FFFF, 45'h1FFF_FFFF_FFFF,
             (108'd1 << 90) - (108'd1 << 63) - (108'd1 << 45), 1'b1);
        wait_drain();

        // Backpressure on A, then B accepted on the DONE handshake.
        out_ready = 1'b0;
        send(45'h1234, 45'd3, 45'd0, 45'd0, 45'd0, 45'd0, 108'h000C_1234, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("held_out_valid", {107'd0, out_valid}, 108'd1);
        chk("held_res", res, 108'h000C_1234);
        out_ready = 1'b1;
        send(45'd0, 45'd0, 45'd0, 45'd2, 45'd0, 45'd1, 108'h8000_0000_1000_0000, 1'b1);
        chk("b2b_busy", {107'd0, busy}, 108'd1);
        wait_drain();

        // Abort in ACC1.
        send(45'd7, 45'd7, 45'd7, 45'd7, 45'd7, 45'd7, 108'd0, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {107'd0, in_ready}, 108'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy",      {107'd0, busy},      108'd0);
        chk("abort_out_valid", {107'd0, out_valid}, 108'd0);
        chk("abort_res",       res,                 108'd0);
        repeat (6) @(posedge clk);
        #1;
        send(45'd0, 45'd0, 45'd1, 45'd0, 45'd0, 45'd0, 108'h10_0000_0000, 1'b1);
        wait_drain();

        // Reset asserted in ACC1: immediate return to reset values, no result.
        send(45'd5, 45'd5, 45'd5, 45'd5, 45'd5, 45'd5, 108'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {107'd0, out_valid}, 108'd0);
        chk("midrst_in_ready",  {107'd0, in_ready},  108'd1);
        chk("midrst_busy",      {107'd0, busy},      108'd0);
        chk("midrst_res",       res,                 108'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_idle", {106'd0, busy, out_valid}, 108'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
